// File: rtl/conv_window_seq_pkg.sv
// Shared types and default widths for the convolution window sequencer.
package conv_pkg;
   localparam int AW_DEF = 4;
   localparam int NW_DEF = 3;

   typedef enum logic [1:0] {
      UNCFG   = 2'd0,
      RUN     = 2'd1,
      ROW_END = 2'd2
   } state_t;
endpackage

// File: rtl/conv_window_seq_wrap_counter.sv
// Modulo counter: counts 0..max on inc, wraps to 0, clr takes priority.
module wrap_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);
   logic [WIDTH-1:0] count_r;

   assign wrap  = inc && (count_r == max);
   assign count = count_r;

   // count register with synchronous clear and wrap at max
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc) begin
         count_r <= wrap ? '0 : count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end
endmodule

// File: rtl/conv_window_seq.sv
// Sliding-window address sequencer for a 1-D convolution over one ifmap row.
// Optional debug window counter enabled by CONV_WINDOW_SEQ_DBG_CNT_EN.
module conv_window_seq
   import conv_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int NW = NW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_fileSize,
   input  logic             ld_stride,
   input  logic [AW-1:0]    filter_size_in,
   input  logic [AW-1:0]    row_len_in,
   input  logic [NW-1:0]    num_filters_in,
   input  logic [AW-1:0]    stride_in,
   input  logic             put,
   input  logic             next_filter,
   input  logic             next_row,
   output logic [AW-1:0]    if_raddr,
   output logic [AW+NW-1:0] f_raddr,
   output logic             co_filter,
   output logic             end_of_row,
`ifdef CONV_WINDOW_SEQ_DBG_CNT_EN
   output logic [15:0]      dbg_win_cnt,
`endif
   output logic             end_of_filter
);
   state_t           state_r;
   logic [AW-1:0]    k_cfg_r;
   logic [AW-1:0]    w_cfg_r;
   logic [AW-1:0]    s_cfg_r;
   logic [NW-1:0]    n_cfg_r;
   logic [AW-1:0]    base_r;
   logic             size_seen_r;
   logic             stride_seen_r;

   logic [AW-1:0]    tap_s;
   logic [NW-1:0]    filt_s;
   logic             tap_wrap_s;
   logic             filt_wrap_s;
   logic             any_ld_s;
   logic             run_s;
   logic             row_end_s;
   logic             too_big_s;
   logic             advance_s;
   logic             tap_inc_s;
   logic             tap_clr_s;
   logic             filt_inc_s;
   logic             filt_clr_s;
   logic             both_cfg_s;
   logic [AW:0]      next_end_s;
   logic             fits_s;
   logic [AW+NW-1:0] f_base_s;

   assign any_ld_s   = ld_fileSize | ld_stride;
   assign run_s      = (state_r == RUN);
   assign row_end_s  = (state_r == ROW_END);
   assign too_big_s  = (k_cfg_r > w_cfg_r);
   assign advance_s  = row_end_s && (next_filter || next_row);
   assign both_cfg_s = (ld_fileSize || size_seen_r) && (ld_stride || stride_seen_r);

   // A window that cannot fit the row never accepts taps; the FSM closes the row instead.
   assign tap_inc_s  = run_s && put && !too_big_s;
   assign tap_clr_s  = any_ld_s || advance_s;
   assign filt_inc_s = row_end_s && next_filter && !next_row;
   assign filt_clr_s = any_ld_s || (row_end_s && next_row);

   wrap_counter #(.WIDTH(AW)) u_tap (
      .clk   (clk),
      .rst   (rst),
      .inc   (tap_inc_s),
      .clr   (tap_clr_s),
      .max   (k_cfg_r - AW'(1)),
      .count (tap_s),
      .wrap  (tap_wrap_s)
   );

   wrap_counter #(.WIDTH(NW)) u_filt (
      .clk   (clk),
      .rst   (rst),
      .inc   (filt_inc_s),
      .clr   (filt_clr_s),
      .max   (n_cfg_r - NW'(1)),
      .count (filt_s),
      .wrap  (filt_wrap_s)
   );

   // b stays within W-K, so b+S+K fits in AW+1 bits without wrapping
   assign next_end_s = {1'b0, base_r} + {1'b0, s_cfg_r} + {1'b0, k_cfg_r};
   assign fits_s     = (next_end_s <= {1'b0, w_cfg_r});
   assign f_base_s   = AW'(filt_s) * (AW+NW)'(k_cfg_r);

   assign if_raddr      = base_r + tap_s;
   assign f_raddr       = f_base_s + (AW+NW)'(tap_s);
   assign co_filter     = tap_wrap_s;
   assign end_of_row    = row_end_s;
   assign end_of_filter = row_end_s && (filt_s == (n_cfg_r - NW'(1)));

   // configuration latches, window base and sequencing FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= UNCFG;
         k_cfg_r       <= '0;
         w_cfg_r       <= '0;
         s_cfg_r       <= '0;
         n_cfg_r       <= '0;
         base_r        <= '0;
         size_seen_r   <= 1'b0;
         stride_seen_r <= 1'b0;
      end else begin
         if (ld_fileSize) begin
            k_cfg_r     <= (filter_size_in == '0) ? AW'(1) : filter_size_in;
            w_cfg_r     <= row_len_in;
            n_cfg_r     <= (num_filters_in == '0) ? NW'(1) : num_filters_in;
            size_seen_r <= 1'b1;
         end else begin
            size_seen_r <= size_seen_r;
         end
         if (ld_stride) begin
            s_cfg_r       <= (stride_in == '0) ? AW'(1) : stride_in;
            stride_seen_r <= 1'b1;
         end else begin
            stride_seen_r <= stride_seen_r;
         end

         if (any_ld_s) begin
            base_r <= '0;
            if ((state_r != UNCFG) || both_cfg_s) begin
               state_r <= RUN;
            end else begin
               state_r <= UNCFG;
            end
         end else begin
            case (state_r)
               UNCFG: begin
                  state_r <= UNCFG;
               end
               RUN: begin
                  if (too_big_s) begin
                     state_r <= ROW_END;
                  end else if (tap_wrap_s) begin
                     if (fits_s) begin
                        base_r <= base_r + s_cfg_r;
                     end else begin
                        state_r <= ROW_END;
                     end
                  end else begin
                     state_r <= RUN;
                  end
               end
               ROW_END: begin
                  if (next_filter || next_row) begin
                     state_r <= RUN;
                     base_r  <= '0;
                  end else begin
                     state_r <= ROW_END;
                  end
               end
               default: begin
                  state_r <= UNCFG;
                  base_r  <= '0;
               end
            endcase
         end
      end
   end

`ifdef CONV_WINDOW_SEQ_DBG_CNT_EN
   logic [15:0] dbg_cnt_r;

   assign dbg_win_cnt = dbg_cnt_r;

   // saturating count of completed windows, restarted by any reconfiguration
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dbg_cnt_r <= 16'h0000;
      end else if (any_ld_s) begin
         dbg_cnt_r <= 16'h0000;
      end else if (co_filter && (dbg_cnt_r != 16'hFFFF)) begin
         dbg_cnt_r <= dbg_cnt_r + 16'h0001;
      end else begin
         dbg_cnt_r <= dbg_cnt_r;
      end
   end
`endif

endmodule

// File: doc/conv_window_seq.md
CONV_WINDOW_SEQ -- requirements
Module: conv_window_seq

Interface
REQ-001 Parameter AW, default 4: width of every address, size and count field (buffers of 2**AW entries).
REQ-002 Parameter NW, default 3: width of the filter-count field.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ld_fileSize  in  1  latch filter_size_in, row_len_in, num_filters_in.
REQ-006 ld_stride  in  1  latch stride_in.
REQ-007 filter_size_in  in  AW  taps per window (K); row_len_in  in  AW  ifmap row length (W); num_filters_in  in  NW  filter count (N); stride_in  in  AW  window step (S).
REQ-008 put  in  1  one tap consumed this cycle, i.e. the controller's put_data.
REQ-009 next_filter  in  1  advance to next filter; next_row  in  1  advance to next ifmap row.
REQ-010 if_raddr  out  AW  ifmap buffer read address; f_raddr  out  AW+NW  filter buffer read address.
REQ-011 co_filter  out  1  last tap of current window consumed; end_of_row  out  1  current row exhausted for current filter; end_of_filter  out  1  last filter of the row reached.

Function
REQ-012 States: UNCFG, RUN, ROW_END.
- UNCFG -> RUN once both loads have occurred, in any order or in the same cycle.
- RUN -> ROW_END on a window-closing put with no further window.
- ROW_END -> RUN on next_filter or next_row.
REQ-013 Counters: tap k (0..K-1), window base b, filter index f (0..N-1).
- if_raddr = b+k.
- f_raddr = f*K+k, computed in AW+NW bits.
REQ-014 put in RUN increments k; put with k==K-1 sets k=0 and, if b+2S+K <= W... more exactly, if b+S+K <= W, sets b=b+S; otherwise enters ROW_END. Comparison uses AW+1 bits and never wraps.
REQ-015 co_filter = RUN && put && k==K-1, combinational, same cycle as the last tap.
REQ-016 end_of_row = (state==ROW_END), registered: first high the cycle after the closing put, held until advanced.
REQ-017 end_of_filter = end_of_row && f==N-1.
REQ-018 In ROW_END, next_row (priority, even with next_filter) clears f, b and k. next_filter alone increments f and clears b and k. Either returns to RUN next cycle.
REQ-019 put is ignored in UNCFG and ROW_END; next_filter and next_row are ignored outside ROW_END.
REQ-020 A load in RUN or ROW_END updates the field, clears k, b and f, and enters RUN.
REQ-021 Degenerate loads: K=0 latches 1, S=0 latches 1, N=0 latches 1. If K>W, RUN goes directly to ROW_END on the next cycle without any put.

Reset
REQ-022 On rst low, immediately:
- state=UNCFG; K, S, W, N, k, b, f and load flags all 0.
- if_raddr=0, f_raddr=0; co_filter, end_of_row, end_of_filter all 0.
REQ-023 Reset deassertion mid-row restarts from UNCFG; a fresh ld_fileSize and ld_stride are both required.

Configuration
REQ-024 Macro CONV_WINDOW_SEQ_DBG_CNT_EN defined:
- Adds output dbg_win_cnt (16 bits), counting co_filter pulses.
- Saturates at 16'hFFFF; cleared by reset and by any load.
REQ-025 Macro undefined: the port and counter are absent, and the remaining behaviour is identical.

Structure
REQ-026 Shared package conv_pkg holds the state enum (UNCFG/RUN/ROW_END) and default AW/NW constants.
REQ-027 One sub-module, wrap_counter (parameterised width, inc/clr/max inputs, wrap output), is used for k and f.

Verification
REQ-028 W=8, K=3, S=1, N=2; 18 puts -> co_filter at puts 3, 6, ..., 18; end_of_row rises the cycle after put 18; end_of_filter=0.
REQ-029 Same config, next_filter, then 18 puts -> f_raddr sequence 3,4,5,...; end_of_row and end_of_filter both 1 after put 18; next_row+next_filter -> f=0, b=0, RUN.
REQ-030 W=8, K=3, S=2 -> if_raddr window bases 0, 2, 4; end_of_row after the 9th put; puts during ROW_END leave addresses unchanged.
REQ-031 K=5, W=4 -> end_of_row one cycle after entering RUN, with no puts.
REQ-032 rst low during put 7 of REQ-028 -> all outputs 0 at once; puts after release ignored until both loads are repeated.
REQ-033 With CONV_WINDOW_SEQ_DBG_CNT_EN, the REQ-028 run -> dbg_win_cnt=6; a reload -> 0.
